// File: rtl/regfile_wb_pkg.sv
// Shared types for the RegFile write-back scheduler.
// Default widths match the 8-bit split RegFile with four registers.
package regfile_wb_pkg;
  localparam int WB_W = 8;
  localparam int WB_A = 2;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} wb_state_e;
  typedef enum logic {SRC_ALU, SRC_LSU} wb_src_e;

  typedef struct packed {
    logic [WB_A-1:0]   addr;
    logic [2*WB_W-1:0] data;
    logic              wide;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: req[0]=ALU, req[1]=LSU, one-hot gnt.
// rr_last moves only when the granted request is actually accepted (advance).
module rr_arb2
  import regfile_wb_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  wb_src_e rr_last_q, rr_last_d;

  always_comb begin
    gnt       = 2'b00;
    rr_last_d = rr_last_q;
    if (req == 2'b11) begin
      gnt = (rr_last_q == SRC_LSU) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    if (advance) begin
      rr_last_d = gnt[1] ? SRC_LSU : SRC_ALU;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) rr_last_q <= SRC_LSU;
    else       rr_last_q <= rr_last_d;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler sharing the RegFile write port between ALU and LSU;
// wide results are written as a low beat then a high beat, owning uppOrLow.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int               W         = WB_W,
  parameter int               A         = WB_A,
  parameter logic [2**A-1:0]  WIDE_MASK = 4'b1001
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           alu_valid,
  output logic           alu_ready,
  input  logic [A-1:0]   alu_addr,
  input  logic [2*W-1:0] alu_data,
  input  logic           alu_wide,
  input  logic           lsu_valid,
  output logic           lsu_ready,
  input  logic [A-1:0]   lsu_addr,
  input  logic [2*W-1:0] lsu_data,
  input  logic           lsu_wide,
  input  logic           rd_upp_or_low,
  output logic           rf_write_en,
  output logic [A-1:0]   rf_waddr,
  output logic [W-1:0]   rf_data_in,
  output logic           rf_upp_or_low,
  output logic           rd_stall,
  output logic           err_wide,
  output logic           wb_busy
);
  wb_state_e  state_q, state_d;
  wb_req_t    op_q, op_d;
  logic       err_wide_q, err_wide_d;
  logic [1:0] gnt;
  logic       can_accept, accept, wide_ok;
  wb_req_t    req_sel;

  rr_arb2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     ({lsu_valid, alu_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  always_comb begin
    // A new op may start whenever the current one finishes in this cycle.
    can_accept = !Reset && ((state_q == S_IDLE) ||
                            (state_q == S_LO && !op_q.wide) ||
                            (state_q == S_HI));
    alu_ready  = can_accept & gnt[0];
    lsu_ready  = can_accept & gnt[1];
    accept     = can_accept & (|gnt);

    req_sel = gnt[1] ? '{addr: lsu_addr, data: lsu_data, wide: lsu_wide}
                     : '{addr: alu_addr, data: alu_data, wide: alu_wide};
    wide_ok = WIDE_MASK[req_sel.addr];

    state_d    = S_IDLE;
    op_d       = op_q;
    err_wide_d = 1'b0;
    if (accept) begin
      op_d       = req_sel;
      op_d.wide  = req_sel.wide & wide_ok;
      err_wide_d = req_sel.wide & ~wide_ok;
      state_d    = S_LO;
    end else if (state_q == S_LO && op_q.wide) begin
      state_d = S_HI;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      err_wide_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      err_wide_q <= err_wide_d;
    end
  end

  always_comb begin
    rf_write_en   = 1'b0;
    rf_waddr      = '0;
    rf_data_in    = '0;
    rf_upp_or_low = rd_upp_or_low;
    case (state_q)
      S_LO: begin
        rf_write_en   = 1'b1;
        rf_waddr      = op_q.addr;
        rf_data_in    = op_q.data[W-1:0];
        rf_upp_or_low = 1'b0;
      end
      S_HI: begin
        rf_write_en   = 1'b1;
        rf_waddr      = op_q.addr;
        rf_data_in    = op_q.data[2*W-1:W];
        rf_upp_or_low = 1'b1;
      end
      default: ;
    endcase
    rd_stall = rf_write_en & (rf_upp_or_low != rd_upp_or_low);
    err_wide = err_wide_q;
    wb_busy  = (state_q != S_IDLE);
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs driven and outputs sampled
// on the falling edge; expected values are hand-computed constants.
module tb_regfile_wb_arbiter;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        alu_valid, alu_wide, lsu_valid, lsu_wide, rd_upp_or_low;
  logic [1:0]  alu_addr, lsu_addr;
  logic [15:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        rf_write_en, rf_upp_or_low, rd_stall, err_wide, wb_busy;
  logic [1:0]  rf_waddr;
  logic [7:0]  rf_data_in;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_wide(alu_wide),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
    .lsu_data(lsu_data), .lsu_wide(lsu_wide),
    .rd_upp_or_low(rd_upp_or_low),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_data_in(rf_data_in),
    .rf_upp_or_low(rf_upp_or_low), .rd_stall(rd_stall),
    .err_wide(err_wide), .wb_busy(wb_busy)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk_write(input string tag, input logic [1:0] a, input logic [7:0] d, input logic upp);
    check_eq({tag, "_we"},   rf_write_en, 1);
    check_eq({tag, "_addr"}, rf_waddr, a);
    check_eq({tag, "_din"},  rf_data_in, d);
    check_eq({tag, "_upp"},  rf_upp_or_low, upp);
  endtask

  task automatic chk_idle(input string tag);
    check_eq({tag, "_we"},   rf_write_en, 0);
    check_eq({tag, "_addr"}, rf_waddr, 0);
    check_eq({tag, "_din"},  rf_data_in, 0);
    check_eq({tag, "_busy"}, wb_busy, 0);
  endtask

  initial begin
    Reset = 1'b1;
    alu_valid = 0; alu_wide = 0; alu_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_wide = 0; lsu_addr = 0; lsu_data = 0;
    rd_upp_or_low = 0;
    @(negedge Clk);
    step();
    // Reset state; readys must stay low even with requests present.
    alu_valid = 1; lsu_valid = 1;
    #1;
    chk_idle("rst");
    check_eq("rst_err", err_wide, 0);
    check_eq("rst_stall", rd_stall, 0);
    check_eq("rst_alu_rdy", alu_ready, 0);
    check_eq("rst_lsu_rdy", lsu_ready, 0);
    alu_valid = 0; lsu_valid = 0;
    step();
    Reset = 0;

    // 1: ALU narrow
    alu_valid = 1; alu_addr = 2'd1; alu_data = 16'h00A5; alu_wide = 0;
    #1 check_eq("t1_alu_rdy", alu_ready, 1);
    step();
    alu_valid = 0;
    chk_write("t1", 2'd1, 8'hA5, 0);
    check_eq("t1_busy", wb_busy, 1);
    step();
    chk_idle("t1_end");

    // 2: LSU wide to split address 0
    lsu_valid = 1; lsu_addr = 2'd0; lsu_data = 16'hBEEF; lsu_wide = 1;
    #1 check_eq("t2_lsu_rdy", lsu_ready, 1);
    step();
    chk_write("t2_lo", 2'd0, 8'hEF, 0);
    check_eq("t2_lo_stall", rd_stall, 0);
    #1 check_eq("t2_lo_lsu_rdy", lsu_ready, 0);
    lsu_valid = 0;
    step();
    chk_write("t2_hi", 2'd0, 8'hBE, 1);
    check_eq("t2_hi_busy", wb_busy, 1);
    step();
    chk_idle("t2_end");
    lsu_wide = 0;

    // 3: contention, narrow, held three cycles
    alu_valid = 1; alu_addr = 2'd2; alu_data = 16'h0011;
    lsu_valid = 1; lsu_addr = 2'd3; lsu_data = 16'h0022;
    #1;
    check_eq("t3_c0_alu_rdy", alu_ready, 1);
    check_eq("t3_c0_lsu_rdy", lsu_ready, 0);
    step();
    chk_write("t3_w1", 2'd2, 8'h11, 0);
    #1;
    check_eq("t3_c1_alu_rdy", alu_ready, 0);
    check_eq("t3_c1_lsu_rdy", lsu_ready, 1);
    step();
    chk_write("t3_w2", 2'd3, 8'h22, 0);
    #1;
    check_eq("t3_c2_alu_rdy", alu_ready, 1);
    check_eq("t3_c2_lsu_rdy", lsu_ready, 0);
    step();
    alu_valid = 0; lsu_valid = 0;
    chk_write("t3_w3", 2'd2, 8'h11, 0);
    step();
    chk_idle("t3_end");

    // 4: wide to a non-split address collapses to one low-byte write
    alu_valid = 1; alu_addr = 2'd1; alu_data = 16'h1234; alu_wide = 1;
    step();
    alu_valid = 0;
    chk_write("t4", 2'd1, 8'h34, 0);
    check_eq("t4_err", err_wide, 1);
    step();
    chk_idle("t4_end");
    check_eq("t4_err_end", err_wide, 0);

    // 5: stall on high beat, then reset mid-op
    rd_upp_or_low = 0;
    alu_valid = 1; alu_addr = 2'd0; alu_data = 16'h5A3C; alu_wide = 1;
    step();
    alu_valid = 0;
    chk_write("t5_lo", 2'd0, 8'h3C, 0);
    check_eq("t5_lo_stall", rd_stall, 0);
    step();
    chk_write("t5_hi", 2'd0, 8'h5A, 1);
    check_eq("t5_hi_stall", rd_stall, 1);
    Reset = 1; alu_valid = 1;
    step();
    #1;
    chk_idle("t5_rst");
    check_eq("t5_rst_alu_rdy", alu_ready, 0);
    check_eq("t5_rst_lsu_rdy", lsu_ready, 0);
    alu_valid = 0; alu_wide = 0;
    step();
    Reset = 0;
    rd_upp_or_low = 1;
    #1;
    check_eq("t5_idle_upp", rf_upp_or_low, 1);
    check_eq("t5_idle_stall", rd_stall, 0);
    rd_upp_or_low = 0;
    step();

    // 6: back-to-back narrow ALU stream
    alu_valid = 1; alu_wide = 0; alu_addr = 2'd0; alu_data = 16'h0040;
    #1 check_eq("t6_rdy0", alu_ready, 1);
    step();
    for (int i = 1; i < 8; i++) begin
      chk_write($sformatf("t6_w%0d", i - 1), 2'((i - 1) % 4), 8'(8'h40 + i - 1), 0);
      alu_addr = 2'(i % 4); alu_data = 16'(16'h0040 + i);
      #1 check_eq($sformatf("t6_rdy%0d", i), alu_ready, 1);
      step();
    end
    alu_valid = 0;
    chk_write("t6_w7", 2'd3, 8'h47, 0);
    step();
    chk_idle("t6_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
